// File: rtl/irq_encoder8_3.sv
// irq_encoder8_3: captures request rising edges into a pending vector and grants them as a
// 3-bit index over a valid/ack handshake. Define ROUND_ROBIN_EN for rotating priority.
module irq_encoder8_3 #(
    parameter real DELAY = 0.05
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] req,
    input  logic       en,
    input  logic       ack,
    output logic [2:0] idx,
    output logic       valid,
    output logic [7:0] pending
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] req_q;
    logic [7:0] rise;
    logic [7:0] clr;
    logic [7:0] pending_nxt;
    logic [2:0] sel;
    logic       load;

    // DELAY only annotates simulation timing; the synthesized encode carries no delay.
    if (DELAY < 0.0) begin : g_delay_annotation
    end

`ifdef ROUND_ROBIN_EN
    logic [2:0] last;

    function automatic logic [2:0] pick_rr(input logic [7:0] v, input logic [2:0] start);
        logic [2:0] r;
        logic [2:0] j;
        logic       found;
        r     = start;
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
            j = start + 3'(k);
            if (!found && v[j]) begin
                r     = j;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    assign sel = pick_rr(pending, last + 3'd1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last <= 3'd7;
        end else if (load) begin
            last <= sel;
        end
    end
`else
    function automatic logic [2:0] pick_high(input logic [7:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) begin
                r = 3'(i);
            end
        end
        return r;
    endfunction

    assign sel = pick_high(pending);
`endif

    assign rise        = req & ~req_q;
    assign clr         = (ack && valid) ? (8'b1 << idx) : 8'h00;
    // New edges are OR-ed in after the clear, so a re-request during its own ack survives.
    assign pending_nxt = (pending & ~clr) | rise;
    assign valid       = (state == GRANT);

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (en && (pending != 8'h00)) begin
                    load      = 1'b1;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (ack) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            req_q   <= 8'h00;
            pending <= 8'h00;
            idx     <= 3'd0;
        end else begin
            state   <= state_nxt;
            req_q   <= req;
            pending <= pending_nxt;
            if (load) begin
                idx <= sel;
            end
        end
    end

endmodule

// File: tb/tb_irq_encoder8_3.sv
// Bench for irq_encoder8_3: directed vector table, hand sequences and a random run
// compared every cycle against a behavioural model of the request/grant rules.
module tb_irq_encoder8_3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic [7:0] req = 8'h00;
    logic       en = 1'b0;
    logic       ack = 1'b0;
    logic [2:0] idx;
    logic       valid;
    logic [7:0] pending;

    always #5 clk = ~clk;

    irq_encoder8_3 dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .en      (en),
        .ack     (ack),
        .idx     (idx),
        .valid   (valid),
        .pending (pending)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Behavioural model state
    bit m_p[8];
    bit m_prev[8];
    bit m_valid;
    int m_idx;
    int m_last;

    typedef struct {
        logic [7:0] req;
        logic       en;
        logic       ack;
        logic       vld;
        logic [2:0] idx;
        logic [7:0] pend;
    } vec_t;

    vec_t tbl[23];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic int model_pick();
`ifdef ROUND_ROBIN_EN
        for (int k = 1; k <= 8; k++) begin
            if (m_p[(m_last + k) % 8]) return (m_last + k) % 8;
        end
`else
        for (int s = 7; s >= 0; s--) begin
            if (m_p[s]) return s;
        end
`endif
        return -1;
    endfunction

    function automatic int model_pend();
        int v = 0;
        for (int i = 0; i < 8; i++) begin
            if (m_p[i]) v += (1 << i);
        end
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_p[i]    = 1'b0;
            m_prev[i] = 1'b0;
        end
        m_valid = 1'b0;
        m_idx   = 0;
        m_last  = 7;
    endtask

    task automatic model_step();
        bit np[8];
        int g;
        np = m_p;
        if (m_valid && ack) np[m_idx] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (req[i] && !m_prev[i]) np[i] = 1'b1;
        end
        if (!m_valid) begin
            g = model_pick();
            if (en && g >= 0) begin
                m_idx   = g;
                m_last  = g;
                m_valid = 1'b1;
            end
        end else if (ack) begin
            m_valid = 1'b0;
        end
        m_p = np;
        for (int i = 0; i < 8; i++) m_prev[i] = req[i];
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset_n) model_reset();
        else model_step();
        #1;
        cyc++;
        chk("model_valid", int'(valid), int'(m_valid));
        chk("model_idx", int'(idx), m_idx);
        chk("model_pending", int'(pending), model_pend());
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!valid && n < 12) begin
            tick();
            n++;
        end
        chk(name, int'(valid), 1);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req     = 8'h00;
        ack     = 1'b0;
        en      = 1'b1;
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int rr_alt[4];
        rr_alt = '{2, 5, 2, 5};

        tbl[0]  = '{8'h08, 1'b1, 1'b0, 1'b0, 3'd0, 8'h08};
        tbl[1]  = '{8'h00, 1'b1, 1'b0, 1'b1, 3'd3, 8'h08};
        tbl[2]  = '{8'h00, 1'b1, 1'b1, 1'b0, 3'd3, 8'h00};
        tbl[3]  = '{8'h00, 1'b1, 1'b0, 1'b0, 3'd3, 8'h00};
        tbl[4]  = '{8'h82, 1'b1, 1'b0, 1'b0, 3'd3, 8'h82};
        tbl[5]  = '{8'h82, 1'b1, 1'b0, 1'b1, 3'd7, 8'h82};
        tbl[6]  = '{8'h00, 1'b1, 1'b1, 1'b0, 3'd7, 8'h02};
        tbl[7]  = '{8'h00, 1'b1, 1'b0, 1'b1, 3'd1, 8'h02};
        tbl[8]  = '{8'h00, 1'b1, 1'b1, 1'b0, 3'd1, 8'h00};
        tbl[9]  = '{8'h00, 1'b1, 1'b0, 1'b0, 3'd1, 8'h00};
        tbl[10] = '{8'h00, 1'b1, 1'b1, 1'b0, 3'd1, 8'h00};
        tbl[11] = '{8'h10, 1'b0, 1'b0, 1'b0, 3'd1, 8'h10};
        tbl[12] = '{8'h10, 1'b0, 1'b1, 1'b0, 3'd1, 8'h10};
        tbl[13] = '{8'h10, 1'b1, 1'b0, 1'b1, 3'd4, 8'h10};
        tbl[14] = '{8'h00, 1'b0, 1'b0, 1'b1, 3'd4, 8'h10};
        tbl[15] = '{8'h10, 1'b0, 1'b0, 1'b1, 3'd4, 8'h10};
        tbl[16] = '{8'h10, 1'b0, 1'b1, 1'b0, 3'd4, 8'h00};
        tbl[17] = '{8'h00, 1'b1, 1'b0, 1'b0, 3'd4, 8'h00};
        tbl[18] = '{8'h40, 1'b1, 1'b0, 1'b0, 3'd4, 8'h40};
        tbl[19] = '{8'h00, 1'b1, 1'b0, 1'b1, 3'd6, 8'h40};
        tbl[20] = '{8'h40, 1'b1, 1'b1, 1'b0, 3'd6, 8'h40};
        tbl[21] = '{8'h40, 1'b1, 1'b0, 1'b1, 3'd6, 8'h40};
        tbl[22] = '{8'h00, 1'b1, 1'b1, 1'b0, 3'd6, 8'h00};

        // Reset held with all requests high
        model_reset();
        req = 8'hFF;
        en  = 1'b1;
        #1 reset_n = 1'b0;
        #2;
        chk("rst_valid", int'(valid), 0);
        chk("rst_idx", int'(idx), 0);
        chk("rst_pending", int'(pending), 0);
        tick();
        tick();
        req     = 8'h00;
        reset_n = 1'b1;
        repeat (5) tick();
        chk("idle_valid", int'(valid), 0);

        // Directed vector table
        for (int i = 0; i < 23; i++) begin
            req = tbl[i].req;
            en  = tbl[i].en;
            ack = tbl[i].ack;
            tick();
            chk($sformatf("tbl%0d_valid", i), int'(valid), int'(tbl[i].vld));
            chk($sformatf("tbl%0d_idx", i), int'(idx), int'(tbl[i].idx));
            chk($sformatf("tbl%0d_pending", i), int'(pending), int'(tbl[i].pend));
        end

        // Random traffic against the model
        for (int i = 0; i < 500; i++) begin
            req = 8'($urandom);
            en  = ($urandom_range(0, 3) != 0);
            ack = 1'($urandom_range(0, 1));
            tick();
        end

        // Reset in the middle of a grant
        ack = 1'b0;
        en  = 1'b1;
        req = 8'h00;
        tick();
        req = 8'h01;
        tick();
        req = 8'h00;
        wait_valid("mg_wait");
        #3 reset_n = 1'b0;
        #1;
        model_reset();
        chk("mg_valid", int'(valid), 0);
        chk("mg_pending", int'(pending), 0);
        chk("mg_idx", int'(idx), 0);
        tick();

        // Request already high when reset releases counts as an edge
        req     = 8'h01;
        reset_n = 1'b1;
        tick();
        chk("rel_edge_pending", int'(pending), 1);
        req = 8'h00;
        wait_valid("rel_wait");
        chk("rel_idx", int'(idx), 0);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("rel_ack_valid", int'(valid), 0);

`ifdef ROUND_ROBIN_EN
        // Two requests kept re-pending alternate
        do_reset();
        req = 8'h24;
        tick();
        req = 8'h00;
        tick();
        for (int k = 0; k < 4; k++) begin
            wait_valid("rr_alt_wait");
            chk($sformatf("rr_alt%0d", k), int'(idx), rr_alt[k]);
            ack = 1'b1;
            req = 8'(1 << idx);
            tick();
            ack = 1'b0;
            req = 8'h00;
            tick();
        end

        // Full pending vector walks 0..7
        do_reset();
        req = 8'hFF;
        tick();
        for (int k = 0; k < 8; k++) begin
            wait_valid("rr_walk_wait");
            chk($sformatf("rr_walk%0d", k), int'(idx), k);
            ack = 1'b1;
            tick();
            ack = 1'b0;
            tick();
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
